// File: rtl/board_io_pkg.sv
// Shared constants for the board input front end: channel counts, clock rate, debounce default.
// Channel order everywhere is {button_2, button_mb[3:0], dip[7:0]}, bit 0 = dip[0].
package board_io_pkg;

  localparam int N_BTN = 5;
  localparam int N_DIP = 8;
  localparam int N_CH  = N_DIP + N_BTN;

  localparam int CLK_HZ              = 50_000_000;
  localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;

  // Synchroniser reset values in pin polarity (main-board buttons idle high).
  localparam logic [N_CH-1:0] SYNC_RST_PIN = 13'b0_1111_0000_0000;
  // Channels whose pins are active low; inverted before the debouncer.
  localparam logic [N_CH-1:0] CH_INVERT    = 13'b0_1111_0000_0000;

  // Reset value seen by a channel's synchroniser after the pin inversion.
  function automatic logic chan_sync_rst(input int idx);
    return SYNC_RST_PIN[idx] ^ CH_INVERT[idx];
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchroniser then a stability counter; output follows after
// DEBOUNCE_CYCLES consecutive differing samples (1+DEBOUNCE_CYCLES edges). No backpressure.
module debounce_channel
  import board_io_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter logic SYNC_RST        = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= SYNC_RST;
      sync2  <= SYNC_RST;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any return to the current level discards the partial count.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_input_conditioner.sv
// Board pins -> debounced DIP/button levels for the MIPS core plus sticky press events.
// Level latency 1+DEBOUNCE_CYCLES edges, events one edge later; set beats clear, no backpressure.
module board_input_conditioner
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       button_mb,
  input  logic             button_2,
  input  logic [7:0]       dip,
  output logic [3:0]       A_dip_lsb,
  output logic [3:0]       B_dip_msb,
  output logic [N_BTN-1:0] C_button,
  output logic [N_BTN-1:0] press_event,
  input  logic [N_BTN-1:0] event_clear
);

  logic [N_CH-1:0]  raw;
  logic [N_CH-1:0]  stable;
  logic [N_BTN-1:0] prev;
  logic [N_BTN-1:0] set;

  // Every channel is active high from here on.
  assign raw = {button_2, button_mb, dip} ^ CH_INVERT;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .SYNC_RST       (chan_sync_rst(i))
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[i]),
      .stable(stable[i])
    );
  end

  assign A_dip_lsb = stable[3:0];
  assign B_dip_msb = stable[7:4];
  assign C_button  = stable[N_CH-1:N_DIP];

  assign set = C_button & ~prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev        <= '0;
      press_event <= '0;
    end else begin
      prev        <= C_button;
      press_event <= set | (press_event & ~event_clear);
    end
  end

endmodule

// File: tb/tb_board_input_conditioner.sv
// Scoreboard bench for board_input_conditioner with DEBOUNCE_CYCLES = 4.
// Expectations are queued with a due edge when stimulus is driven and compared on that edge.
module tb_board_input_conditioner;

  localparam logic [17:0] M_A = 18'h0000F;
  localparam logic [17:0] M_B = 18'h000F0;
  localparam logic [17:0] M_C = 18'h01F00;
  localparam logic [17:0] M_P = 18'h3E000;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] button_mb;
  logic       button_2;
  logic [7:0] dip;
  logic [3:0] A_dip_lsb;
  logic [3:0] B_dip_msb;
  logic [4:0] C_button;
  logic [4:0] press_event;
  logic [4:0] event_clear;

  board_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .button_mb  (button_mb),
    .button_2   (button_2),
    .dip        (dip),
    .A_dip_lsb  (A_dip_lsb),
    .B_dip_msb  (B_dip_msb),
    .C_button   (C_button),
    .press_event(press_event),
    .event_clear(event_clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    string       tag;
    logic [17:0] m;
    logic [17:0] v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   rise2 = 0;
  int   set2 = 0;
  logic prev_c2 = 1'b0;
  logic prev_p2 = 1'b0;

  function automatic logic [17:0] f(input logic [4:0] p, input logic [4:0] c,
                                    input logic [3:0] b, input logic [3:0] a);
    return {p, c, b, a};
  endfunction

  function automatic logic [17:0] obs();
    return {press_event, C_button, B_dip_msb, A_dip_lsb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int off, input string tag, input logic [17:0] m, input logic [17:0] v);
    exp_t e;
    e.due = cyc + off;
    e.tag = tag;
    e.m   = m;
    e.v   = v & m;
    q.push_back(e);
  endtask

  // Compare every queued expectation that has come due, and track edge counts on bit 2.
  task automatic service();
    logic [17:0] o;
    o = obs();
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due <= cyc) begin
        chk(q[i].tag, 32'(o & q[i].m), 32'(q[i].v));
        q.delete(i);
      end
    end
    if (C_button[2] && !prev_c2) rise2++;
    if (press_event[2] && !prev_p2) set2++;
    prev_c2 = C_button[2];
    prev_p2 = press_event[2];
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      service();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rise;
    int base_set;

    // 1: reset with everything asserted, then full re-qualification.
    reset = 1'b0;
    dip = 8'hFF;
    button_mb = 4'h0;
    button_2 = 1'b0;
    event_clear = 5'h0;
    tick(3);
    chk("reset_outputs", 32'(obs()), 32'h0);
    reset = 1'b1;
    push(5, "rel_k4_zero", '1, 18'h0);
    push(6, "rel_k5_levels", M_A | M_B | M_C, f(5'h0, 5'b01111, 4'hF, 4'hF));
    push(6, "rel_k5_no_event", M_P, 18'h0);
    push(7, "rel_k6_event", M_P, f(5'b01111, 5'h0, 4'h0, 4'h0));
    tick(9);

    // Release buttons, then clear every sticky event.
    button_mb = 4'hF;
    tick(10);
    push(0, "released_c", M_C | M_P, f(5'b01111, 5'h0, 4'h0, 4'h0));
    tick(1);
    event_clear = 5'h1F;
    push(1, "clear_all", M_P, 18'h0);
    tick(1);
    event_clear = 5'h0;
    tick(2);

    // 2: three-cycle glitch on button_mb[0] must be rejected.
    button_mb[0] = 1'b0;
    for (int d = 1; d <= 12; d++) push(d, "glitch_rejected", 18'h02100, 18'h0);
    tick(3);
    button_mb[0] = 1'b1;
    tick(12);

    // 3: button_2 press for 10 cycles.
    button_2 = 1'b1;
    push(5, "b2_k4_low", 18'h01000, 18'h0);
    push(6, "b2_k5_high", 18'h01000, 18'h01000);
    push(6, "b2_k5_no_event", 18'h20000, 18'h0);
    push(7, "b2_k6_event", 18'h20000, 18'h20000);
    tick(10);
    button_2 = 1'b0;
    tick(10);
    push(1, "b2_release_sticky", 18'h21000, 18'h20000);
    tick(2);

    // 4: lone clear, then clear coincident with a new set, then lone clear on a held button.
    event_clear = 5'h10;
    push(1, "lone_clear1", 18'h20000, 18'h0);
    tick(1);
    event_clear = 5'h0;
    tick(2);
    button_2 = 1'b1;
    push(6, "b2_pre_set", 18'h20000, 18'h0);
    tick(6);
    event_clear = 5'h10;
    push(1, "set_beats_clear", 18'h20000, 18'h20000);
    tick(1);
    event_clear = 5'h0;
    push(1, "set_holds", 18'h20000, 18'h20000);
    tick(3);
    event_clear = 5'h10;
    push(1, "lone_clear2", 18'h20000, 18'h0);
    tick(1);
    event_clear = 5'h0;
    push(4, "held_one_event", 18'h21000, 18'h01000);
    tick(6);

    // 5: reset in the middle of a dip[7] qualification.
    dip = 8'h7F;
    tick(8);
    push(1, "dip_7f", M_A | M_B, f(5'h0, 5'h0, 4'h7, 4'hF));
    tick(2);
    dip = 8'hFF;
    tick(4);
    reset = 1'b0;
    #1;
    chk("midcount_reset", 32'(obs()), 32'h0);
    tick(3);
    reset = 1'b1;
    push(5, "rerel_k4_zero", M_A | M_B, 18'h0);
    push(6, "rerel_k5", M_A | M_B | M_C, f(5'h0, 5'h10, 4'hF, 4'hF));
    push(6, "rerel_k5_no_event", M_P, 18'h0);
    push(7, "rerel_k6_event", M_P, f(5'h10, 5'h0, 4'h0, 4'h0));
    tick(9);

    // 6: button_mb[2] chatters every cycle, then settles pressed.
    base_rise = rise2;
    base_set = set2;
    for (int d = 5; d <= 25; d += 5) push(d, "chatter_low", 18'h00400, 18'h0);
    for (int i = 0; i < 20; i++) begin
      button_mb[2] = ~button_mb[2];
      tick(1);
    end
    button_mb[2] = 1'b0;
    push(5, "settle_k4_low", 18'h00400, 18'h0);
    push(6, "settle_k5_high", 18'h00400, 18'h00400);
    push(6, "settle_k5_no_event", 18'h08000, 18'h0);
    push(7, "settle_k6_event", 18'h08000, 18'h08000);
    tick(12);
    chk("c2_rise_count", 32'(rise2 - base_rise), 32'd1);
    chk("p2_set_count", 32'(set2 - base_set), 32'd1);

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
